fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, FIFO write-port byte width.
REQ-002 Parameter ALU_WIDTH, default 2*DATA_WIDTH, ALU result width; always exactly two FIFO words.
REQ-003 i_CLK  input  1  FIFO write-domain clock; all state on rising edge.
REQ-004 i_RST  input  1  asynchronous, active-high reset.
REQ-005 i_ALU_VLD  input  1  ALU result request; held high until o_ALU_ACK.
REQ-006 i_ALU_DATA  input  ALU_WIDTH  ALU result; stable while i_ALU_VLD high.
REQ-007 i_RF_VLD  input  1  register-file read-data request; held high until o_RF_ACK.
REQ-008 i_RF_DATA  input  DATA_WIDTH  register-file read data; stable while i_RF_VLD high.
REQ-009 i_FULL  input  1  FIFO full flag, write domain.
REQ-010 o_ALU_ACK  output  1  one-cycle pulse: ALU request captured.
REQ-011 o_RF_ACK  output  1  one-cycle pulse: RF request captured.
REQ-012 o_W_INC  output  1  FIFO write strobe.
REQ-013 o_WR_DATA  output  DATA_WIDTH  FIFO write data.
REQ-014 o_BUSY  output  1  high in any state except IDLE.

Function
REQ-015 FSM states: IDLE, WR_LO, WR_HI, WR_RF; state register, holding register (ALU_WIDTH), last-grant flag.
REQ-016 IDLE, single request: grant it, latch data into holding register, pulse matching ACK in that cycle; next state WR_LO (ALU) or WR_RF (RF).
REQ-017 IDLE, both requests: grant requester not last granted (round-robin); last-grant flag updates on every grant.
REQ-018 IDLE, no request: stay in IDLE; ACKs low; o_W_INC low.
REQ-019 o_W_INC = (state in WR_LO/WR_HI/WR_RF) AND NOT i_FULL; combinational from registered state and i_FULL.
REQ-020 o_WR_DATA: WR_LO holding[DATA_WIDTH-1:0]; WR_HI holding[ALU_WIDTH-1:DATA_WIDTH]; WR_RF holding[DATA_WIDTH-1:0]; IDLE zero.
REQ-021 Transitions on a write (o_W_INC=1): WR_LO->WR_HI, WR_HI->IDLE, WR_RF->IDLE.
REQ-022 i_FULL high: hold state and holding register; no write; no word dropped or duplicated; resume on first cycle i_FULL low.
REQ-023 No grant outside IDLE; requests seen during WR_* wait (no ACK) until IDLE.
REQ-024 ALU result order in FIFO: low byte, then high byte, back-to-back when not full; ALU words never interleave with RF words.
REQ-025 Throughput without backpressure: ALU request = 3 cycles (grant + 2 writes); RF request = 2 cycles.
REQ-026 Requester dropping VLD before ACK: ignored if not granted that cycle; no recovery or error flag.
REQ-027 Last-grant flag resets to ALU, so first simultaneous request after reset grants RF.

Reset
REQ-028 i_RST high asynchronously forces: state IDLE, holding register 0, last-grant ALU; outputs o_ALU_ACK=0, o_RF_ACK=0, o_W_INC=0, o_WR_DATA=0, o_BUSY=0.
REQ-029 Reset mid-transfer aborts it; unwritten bytes discarded; no partial ALU word completed after release.
REQ-030 First grant possible on first rising edge after i_RST deasserts.

Structure
REQ-031 State encodings (IDLE, WR_LO, WR_HI, WR_RF) and grant-ID constants (GNT_ALU, GNT_RF) live in the shared system package.
REQ-032 Single flat module, no sub-modules; round-robin decision inline in IDLE next-state logic.
REQ-033 Connects to the FIFO write side only; performs no clock-domain crossing.

Verification
REQ-034 ALU only, i_ALU_DATA=16'hA55A, i_FULL=0 -> ACK in cycle 0; writes 8'h5A (cycle 1), 8'hA5 (cycle 2); o_BUSY low in cycle 3.
REQ-035 ALU and RF asserted together after reset, RF=8'h3C, ALU=16'h1234 -> RF granted first: writes 3C, then 34, 12; ACKs in cycles 0 and 2.
REQ-036 ALU=16'hBEEF granted, i_FULL high cycles 1-4 -> o_W_INC low cycles 1-4; EF written cycle 5, BE cycle 6; holding register unchanged.
REQ-037 Both requesters continuously valid for 12 cycles -> grants alternate RF, ALU, RF, ALU; FIFO order: RF byte, ALU lo, ALU hi, repeating.
REQ-038 i_RST pulsed in WR_HI after 8'hEF written -> o_W_INC, o_WR_DATA, o_BUSY zero immediately; 8'hBE never written; IDLE after release.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM state encoding
// and the identifiers recorded in the last-grant flag.
package fifo_wr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      WR_RF = 2'd3
   } state_t;

   localparam logic GNT_ALU = 1'b0;
   localparam logic GNT_RF  = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side arbiter: round-robin between an ALU requester (two FIFO
// words, low byte first) and a register-file requester (one FIFO word).
// A granted request is latched into a holding register and then drained
// one word per cycle, stalling while the FIFO reports full.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_ALU_VLD,
   input  logic [ALU_WIDTH-1:0]  i_ALU_DATA,
   input  logic                  i_RF_VLD,
   input  logic [DATA_WIDTH-1:0] i_RF_DATA,
   input  logic                  i_FULL,
   output logic                  o_ALU_ACK,
   output logic                  o_RF_ACK,
   output logic                  o_W_INC,
   output logic [DATA_WIDTH-1:0] o_WR_DATA,
   output logic                  o_BUSY
);

   state_t                state_q, state_d;
   logic [ALU_WIDTH-1:0]  hold_q, hold_d;
   logic                  last_gnt_q, last_gnt_d;
   logic                  alu_gnt, rf_gnt;
   logic                  wr_active;

   // Any non-IDLE state has a word waiting for the FIFO.
   assign wr_active = (state_q != IDLE);
   assign o_BUSY    = wr_active;
   assign o_W_INC   = wr_active && !i_FULL;

   // Acks follow the grant decision in the same cycle; held low while reset
   // is asserted so the requesters never see a capture that did not happen.
   assign o_ALU_ACK = alu_gnt && !i_RST;
   assign o_RF_ACK  = rf_gnt  && !i_RST;

   // Next-state: round-robin grant in IDLE, one word per non-full cycle otherwise.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      last_gnt_d = last_gnt_q;
      alu_gnt    = 1'b0;
      rf_gnt     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_ALU_VLD && i_RF_VLD) begin
               // Both waiting: favour whoever did not win last time.
               if (last_gnt_q == GNT_ALU) rf_gnt  = 1'b1;
               else                       alu_gnt = 1'b1;
            end else if (i_ALU_VLD) begin
               alu_gnt = 1'b1;
            end else if (i_RF_VLD) begin
               rf_gnt = 1'b1;
            end

            if (alu_gnt) begin
               state_d    = WR_LO;
               hold_d     = i_ALU_DATA;
               last_gnt_d = GNT_ALU;
            end else if (rf_gnt) begin
               state_d    = WR_RF;
               hold_d     = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, i_RF_DATA};
               last_gnt_d = GNT_RF;
            end
         end
         WR_LO:   if (!i_FULL) state_d = WR_HI;
         WR_HI:   if (!i_FULL) state_d = IDLE;
         WR_RF:   if (!i_FULL) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write data: pick the holding-register byte that belongs to the current state.
   always_comb begin
      o_WR_DATA = '0;
      case (state_q)
         WR_LO:   o_WR_DATA = hold_q[DATA_WIDTH-1:0];
         WR_HI:   o_WR_DATA = hold_q[ALU_WIDTH-1:DATA_WIDTH];
         WR_RF:   o_WR_DATA = hold_q[DATA_WIDTH-1:0];
         default: o_WR_DATA = '0;
      endcase
   end

   // State, holding register and last-grant flag; reset aborts any transfer.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         last_gnt_q <= GNT_ALU;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios followed by random
// traffic. A transaction-level model predicts grants and pushes the expected
// FIFO byte stream into a scoreboard; a separate monitor pops and compares
// on every write strobe.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_vld, rf_vld, full;
   logic [AW-1:0] alu_data;
   logic [DW-1:0] rf_data;
   logic          alu_ack, rf_ack, w_inc, busy;
   logic [DW-1:0] wr_data;

   int errors = 0;
   int checks = 0;

   // Expected FIFO contents, in order.
   logic [DW-1:0] sb_q[$];
   // Model: words still owed to the FIFO by the current grant, and who won last.
   int  words_left = 0;
   bit  last_was_rf = 1'b0;
   bit  g_alu = 1'b0, g_rf = 1'b0;
   bit  keep_requesting = 1'b0;
   int  cyc = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_ALU_VLD  (alu_vld),
      .i_ALU_DATA (alu_data),
      .i_RF_VLD   (rf_vld),
      .i_RF_DATA  (rf_data),
      .i_FULL     (full),
      .o_ALU_ACK  (alu_ack),
      .o_RF_ACK   (rf_ack),
      .o_W_INC    (w_inc),
      .o_WR_DATA  (wr_data),
      .o_BUSY     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Reference model: evaluated mid-cycle with inputs stable.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_alu_ack", {31'd0, alu_ack}, 0);
         chk("rst_rf_ack",  {31'd0, rf_ack},  0);
         chk("rst_w_inc",   {31'd0, w_inc},   0);
         chk("rst_wr_data", {24'd0, wr_data}, 0);
         chk("rst_busy",    {31'd0, busy},    0);
         sb_q.delete();
         words_left  = 0;
         last_was_rf = 1'b0;
         g_alu = 1'b0;
         g_rf  = 1'b0;
      end else begin
         g_alu = 1'b0;
         g_rf  = 1'b0;
         if (words_left == 0) begin
            if (alu_vld && rf_vld) begin
               if (last_was_rf) g_alu = 1'b1;
               else             g_rf  = 1'b1;
            end else if (alu_vld) begin
               g_alu = 1'b1;
            end else if (rf_vld) begin
               g_rf = 1'b1;
            end
            chk("idle_wr_data", {24'd0, wr_data}, 0);
         end
         chk("alu_ack", {31'd0, alu_ack}, {31'd0, g_alu});
         chk("rf_ack",  {31'd0, rf_ack},  {31'd0, g_rf});
         chk("busy",    {31'd0, busy},    (words_left != 0) ? 1 : 0);
         chk("w_inc",   {31'd0, w_inc},   (words_left != 0 && !full) ? 1 : 0);
         if (words_left != 0 && !full) words_left--;
         if (g_alu) begin
            sb_q.push_back(alu_data[7:0]);
            sb_q.push_back(alu_data[15:8]);
            words_left  = 2;
            last_was_rf = 1'b0;
         end
         if (g_rf) begin
            sb_q.push_back(rf_data);
            words_left  = 1;
            last_was_rf = 1'b1;
         end
      end
   end

   // Monitor: every FIFO write must match the next expected byte.
   always @(negedge clk) begin
      if (!rst && w_inc) begin
         if (sb_q.size() == 0) chk("unexpected_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
         else                  chk("wr_data", {24'd0, wr_data}, {24'd0, sb_q.pop_front()});
      end
   end

   // Advance one cycle; requesters withdraw (or renew) once the model says granted.
   task automatic step();
      @(posedge clk);
      #1;
      if (g_alu) begin
         if (keep_requesting) alu_data = AW'($urandom);
         else                 alu_vld  = 1'b0;
      end
      if (g_rf) begin
         if (keep_requesting) rf_data = DW'($urandom);
         else                 rf_vld  = 1'b0;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1; alu_vld = 1'b0; rf_vld = 1'b0; full = 1'b0;
      alu_data = '0; rf_data = '0;
      steps(3);
      rst = 1'b0;

      // Simultaneous requests straight after reset: RF wins first.
      alu_vld = 1'b1; alu_data = 16'h1234;
      rf_vld  = 1'b1; rf_data  = 8'h3C;
      steps(6);

      // ALU alone: ack, two writes, idle.
      alu_vld = 1'b1; alu_data = 16'hA55A;
      steps(4);

      // ALU with FIFO full for four cycles after the grant.
      alu_vld = 1'b1; alu_data = 16'hBEEF;
      step();
      full = 1'b1;
      steps(4);
      full = 1'b0;
      steps(3);

      // Both requesters continuously valid: grants alternate.
      keep_requesting = 1'b1;
      alu_vld = 1'b1; alu_data = 16'hC0DE;
      rf_vld  = 1'b1; rf_data  = 8'h77;
      steps(12);
      keep_requesting = 1'b0;
      alu_vld = 1'b0; rf_vld = 1'b0;
      steps(4);

      // Reset while the high byte is pending: it must never be written.
      alu_vld = 1'b1; alu_data = 16'hBEEF;
      step();          // grant
      step();          // low byte written, now in the high-byte state
      #2 rst = 1'b1;
      #1;
      chk("abort_w_inc",   {31'd0, w_inc},   0);
      chk("abort_wr_data", {24'd0, wr_data}, 0);
      chk("abort_busy",    {31'd0, busy},    0);
      step();
      rst = 1'b0;
      steps(3);

      // Random traffic with random backpressure.
      for (int i = 0; i < 500; i++) begin
         if (!alu_vld && ($urandom_range(0, 2) == 0)) begin
            alu_vld = 1'b1; alu_data = AW'($urandom);
         end
         if (!rf_vld && ($urandom_range(0, 2) == 0)) begin
            rf_vld = 1'b1; rf_data = DW'($urandom);
         end
         full = ($urandom_range(0, 3) == 0);
         step();
      end

      // Drain with a bounded wait.
      begin
         int budget;
         budget = 0;
         full = 1'b0;
         while ((alu_vld || rf_vld || words_left != 0) && budget < 40) begin
            step();
            budget++;
         end
         chk("drain_timeout", budget, (budget < 40) ? budget : 0);
      end
      step();
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
